// File: rtl/serial_tx_arbiter_if.sv
// serial_tx_arbiter_if: requester and transmitter handshake bundle for the serial TX arbiter
interface serial_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] ReqValid;
  logic [NUM_REQ*DATA_WIDTH-1:0] ReqData;
  logic [NUM_REQ-1:0] ReqAck;
  logic ReqErr;
  logic [DATA_WIDTH-1:0] TxData;
  logic TxSample;
  logic TxStart;
  logic TxBusy;
  logic TxDone;
  logic [ID_W-1:0] GrantId;
  logic Busy;
  logic [7:0] ErrCount;
  modport master (
    input ReqValid, ReqData, TxBusy, TxDone,
    output ReqAck, ReqErr, TxData, TxSample, TxStart, GrantId, Busy, ErrCount
  );
  modport slave (
    output ReqValid, ReqData, TxBusy, TxDone,
    input ReqAck, ReqErr, TxData, TxSample, TxStart, GrantId, Busy, ErrCount
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin sharing of one serial transmitter among NUM_REQ requesters
module serial_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 4095
) (
  input logic Clk,
  input logic Reset,
  serial_tx_arbiter_if.master Bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {IDLE, SAMPLE, START, WAIT_DONE, ACK} state_t;
  state_t state, stateNext;
  logic [ID_W-1:0] lastGrant, lastGrantNext, pick, grantNext;
  logic [WD_W-1:0] wd, wdNext;
  logic errFlag, errFlagNext;
  logic [DATA_WIDTH-1:0] dataNext;
  logic sampleNext, startNext, errNext;
  logic [NUM_REQ-1:0] ackNext;
  logic [7:0] errCountNext;
  // Scan downward so the candidate closest after lastGrant is assigned last and wins.
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (Bus.ReqValid[(int'(lastGrant) + 1 + k) % NUM_REQ])
        pick = ID_W'((int'(lastGrant) + 1 + k) % NUM_REQ);
  end
  always_comb begin
    stateNext = state;
    lastGrantNext = lastGrant;
    grantNext = Bus.GrantId;
    dataNext = Bus.TxData;
    wdNext = wd;
    errFlagNext = errFlag;
    errCountNext = Bus.ErrCount;
    sampleNext = 1'b0;
    startNext = 1'b0;
    errNext = 1'b0;
    ackNext = '0;
    case (state)
      IDLE: if (|Bus.ReqValid) begin
        grantNext = pick;
        dataNext = Bus.ReqData[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
        stateNext = SAMPLE;
      end
      SAMPLE: if (!Bus.TxBusy) begin
        sampleNext = 1'b1;
        stateNext = START;
      end
      START: begin
        startNext = 1'b1;
        wdNext = '0;
        stateNext = WAIT_DONE;
      end
      WAIT_DONE: if (Bus.TxDone) begin
        errFlagNext = 1'b0;
        stateNext = ACK;
      end else if (TIMEOUT != 0) begin
        wdNext = wd + 1'b1;
        if (wdNext == WD_W'(TIMEOUT)) begin
          errFlagNext = 1'b1;
          errCountNext = (Bus.ErrCount == 8'hFF) ? Bus.ErrCount : Bus.ErrCount + 8'd1;
          stateNext = ACK;
        end
      end
      ACK: begin
        ackNext[Bus.GrantId] = 1'b1;
        errNext = errFlag;
        lastGrantNext = Bus.GrantId;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      lastGrant <= ID_W'(NUM_REQ - 1);
      wd <= '0;
      errFlag <= 1'b0;
      Bus.GrantId <= '0;
      Bus.TxData <= '0;
      Bus.TxSample <= 1'b0;
      Bus.TxStart <= 1'b0;
      Bus.ReqAck <= '0;
      Bus.ReqErr <= 1'b0;
      Bus.Busy <= 1'b0;
      Bus.ErrCount <= '0;
    end else begin
      state <= stateNext;
      lastGrant <= lastGrantNext;
      wd <= wdNext;
      errFlag <= errFlagNext;
      Bus.GrantId <= grantNext;
      Bus.TxData <= dataNext;
      Bus.TxSample <= sampleNext;
      Bus.TxStart <= startNext;
      Bus.ReqAck <= ackNext;
      Bus.ReqErr <= errNext;
      Bus.Busy <= stateNext != IDLE;
      Bus.ErrCount <= errCountNext;
    end
  end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: directed checks of arbitration, stall, timeout and reset behaviour
module tb_serial_tx_arbiter;
  logic Clk = 1'b0;
  logic Reset;
  int checkCount = 0;
  int errorCount = 0;
  logic stray;
  logic [31:0] words [4] = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
  int order [5] = '{0, 1, 2, 3, 0};

  serial_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();
  serial_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus16 ();

  serial_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .TIMEOUT(4095)) dut (
    .Clk(Clk), .Reset(Reset), .Bus(bus.master)
  );
  serial_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .TIMEOUT(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .Bus(bus16.master)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge Clk);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return bus.TxSample;
      1: return bus.TxStart;
      2: return |bus.ReqAck;
      3: return bus16.TxSample;
      4: return bus16.TxStart;
      default: return |bus16.ReqAck;
    endcase
  endfunction

  task automatic waitSig(input int sel, input string tag);
    int n = 0;
    while (!sig(sel) && n < 60) begin
      tick;
      n++;
    end
    check(tag, {31'd0, sig(sel)}, 32'd1);
  endtask

  task automatic resetDut;
    Reset = 1'b1;
    repeat (2) tick;
    Reset = 1'b0;
  endtask

  task automatic pulseDone;
    repeat (3) tick;
    bus.TxDone = 1'b1;
    tick;
    bus.TxDone = 1'b0;
  endtask

  task automatic runTx(input int expId, input string tag);
    waitSig(0, {tag, " sample"});
    check({tag, " grant"}, {30'd0, bus.GrantId}, expId);
    check({tag, " data"}, bus.TxData, words[expId]);
    waitSig(1, {tag, " start"});
    pulseDone;
    waitSig(2, {tag, " ack seen"});
    check({tag, " ack"}, {28'd0, bus.ReqAck}, 32'd1 << expId);
    check({tag, " err"}, {31'd0, bus.ReqErr}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    bus.ReqValid = '0; bus.ReqData = '0; bus.TxBusy = 1'b0; bus.TxDone = 1'b0;
    bus16.ReqValid = '0; bus16.ReqData = '0; bus16.TxBusy = 1'b0; bus16.TxDone = 1'b0;
    repeat (2) tick;
    check("rst ack", {28'd0, bus.ReqAck}, 0);
    check("rst err", {31'd0, bus.ReqErr}, 0);
    check("rst data", bus.TxData, 0);
    check("rst strobes", {30'd0, bus.TxSample, bus.TxStart}, 0);
    check("rst grant", {30'd0, bus.GrantId}, 0);
    check("rst busy", {31'd0, bus.Busy}, 0);
    check("rst errcount", {24'd0, bus.ErrCount}, 0);
    Reset = 1'b0;

    bus.ReqData[31:0] = 32'hA5A5_0001;
    bus.ReqValid = 4'b0001;
    tick;
    check("t1 busy", {31'd0, bus.Busy}, 1);
    check("t1 early sample", {31'd0, bus.TxSample}, 0);
    tick;
    check("t1 sample", {31'd0, bus.TxSample}, 1);
    check("t1 data", bus.TxData, 32'hA5A5_0001);
    tick;
    check("t1 start", {31'd0, bus.TxStart}, 1);
    check("t1 sample pulse", {31'd0, bus.TxSample}, 0);
    stray = 1'b0;
    repeat (39) begin
      tick;
      stray |= (|bus.ReqAck) | bus.TxStart | bus.TxSample;
    end
    bus.TxDone = 1'b1;
    tick;
    bus.TxDone = 1'b0;
    check("t1 no early ack", {31'd0, stray | (|bus.ReqAck)}, 0);
    tick;
    check("t1 ack", {28'd0, bus.ReqAck}, 32'b0001);
    check("t1 err", {31'd0, bus.ReqErr}, 0);
    bus.ReqValid = '0;
    tick;
    check("t1 ack pulse", {28'd0, bus.ReqAck}, 0);
    check("t1 idle", {31'd0, bus.Busy}, 0);

    resetDut;
    bus.ReqData = {words[3], words[2], words[1], words[0]};
    bus.ReqValid = 4'hF;
    foreach (order[i]) runTx(order[i], $sformatf("t2 rr%0d", i));
    bus.ReqValid = '0;
    tick;

    resetDut;
    bus.TxBusy = 1'b1;
    bus.ReqValid = 4'b0010;
    tick;
    check("t3 grant", {30'd0, bus.GrantId}, 1);
    stray = 1'b0;
    repeat (9) begin
      tick;
      stray |= bus.TxSample;
    end
    check("t3 stall", {31'd0, stray | bus.TxSample}, 0);
    bus.TxBusy = 1'b0;
    tick;
    check("t3 sample", {31'd0, bus.TxSample}, 1);
    tick;
    check("t3 start", {31'd0, bus.TxStart}, 1);
    pulseDone;
    waitSig(2, "t3 ack seen");
    check("t3 ack", {28'd0, bus.ReqAck}, 32'b0010);
    bus.ReqValid = '0;
    tick;

    resetDut;
    bus16.ReqData = {words[3], words[2], words[1], words[0]};
    bus16.ReqValid = 4'b0011;
    waitSig(4, "t4 start");
    check("t4 grant", {30'd0, bus16.GrantId}, 0);
    stray = 1'b0;
    repeat (16) begin
      tick;
      stray |= |bus16.ReqAck;
    end
    check("t4 no early ack", {31'd0, stray}, 0);
    tick;
    check("t4 ack", {28'd0, bus16.ReqAck}, 32'b0001);
    check("t4 err", {31'd0, bus16.ReqErr}, 1);
    check("t4 errcount", {24'd0, bus16.ErrCount}, 1);
    bus16.ReqValid = 4'b0010;
    waitSig(3, "t4 next sample");
    check("t4 next grant", {30'd0, bus16.GrantId}, 1);
    check("t4 next data", bus16.TxData, words[1]);
    waitSig(4, "t4 next start");
    repeat (2) tick;
    bus16.TxDone = 1'b1;
    tick;
    bus16.TxDone = 1'b0;
    waitSig(5, "t4 next ack seen");
    check("t4 next ack", {28'd0, bus16.ReqAck}, 32'b0010);
    check("t4 next err", {31'd0, bus16.ReqErr}, 0);
    bus16.ReqValid = 4'b0001;

    waitSig(4, "t5 start");
    check("t5 grant", {30'd0, bus16.GrantId}, 0);
    repeat (15) tick;
    bus16.TxDone = 1'b1;
    tick;
    bus16.TxDone = 1'b0;
    tick;
    check("t5 ack", {28'd0, bus16.ReqAck}, 32'b0001);
    check("t5 err", {31'd0, bus16.ReqErr}, 0);
    check("t5 errcount", {24'd0, bus16.ErrCount}, 1);
    bus16.ReqValid = '0;
    tick;

    resetDut;
    bus.ReqValid = 4'b0100;
    waitSig(1, "t6 start");
    repeat (5) tick;
    Reset = 1'b1;
    tick;
    check("t6 rst ack", {28'd0, bus.ReqAck}, 0);
    check("t6 rst busy", {31'd0, bus.Busy}, 0);
    check("t6 rst data", bus.TxData, 0);
    check("t6 rst grant", {30'd0, bus.GrantId}, 0);
    check("t6 rst strobes", {30'd0, bus.TxSample, bus.TxStart}, 0);
    Reset = 1'b0;
    waitSig(0, "t6 resample");
    check("t6 grant", {30'd0, bus.GrantId}, 2);
    check("t6 data", bus.TxData, words[2]);
    waitSig(1, "t6 restart");
    bus.ReqValid = '0;
    pulseDone;
    waitSig(2, "t6 ack seen");
    check("t6 ack after drop", {28'd0, bus.ReqAck}, 32'b0100);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
